// File: rtl/processor_param.sv
// processor_param: parametrised multi-cycle accumulator machine.
//
// Instructions and operands are fetched from one shared memory. Each
// instruction walks FETCH -> IR_LOAD -> DECODE, then goes to OPERAND for
// memory-sourced arithmetic or straight back to FETCH. HALT is terminal
// until reset.
//
// Parameters:
//   DATA_W  accumulator / ALU width
//   ADDR_W  memory address and PC width (memory depth 2^ADDR_W)
//   MEM_W   memory word width (MEM_W >= DATA_W, MEM_W >= ADDR_W+3)
//
// Ports:
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset
//   data_in     memory read data, valid the cycle after address is presented
//   data_out    write data, accumulator zero-extended to MEM_W
//   readwriteN  1 = read, 0 = write (memory writes on the clk edge while 0)
//   address     memory access address
//   halted      1 while in the HALT state
//   pc_out      current program counter (debug)
//   acc_out     accumulator (debug)
module processor_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int MEM_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [MEM_W-1:0]  data_in,
  output logic [MEM_W-1:0]  data_out,
  output logic              readwriteN,
  output logic [ADDR_W-1:0] address,
  output logic              halted,
  output logic [ADDR_W-1:0] pc_out,
  output logic [DATA_W-1:0] acc_out
);

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    IR_LOAD = 3'd1,
    DECODE  = 3'd2,
    OPERAND = 3'd3,
    HALT    = 3'd4
  } state_t;

  localparam logic [2:0] OP_JMP   = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_STORE = 3'b010;
  localparam logic [2:0] OP_ADD   = 3'b011;
  localparam logic [2:0] OP_SUB   = 3'b100;
  localparam logic [2:0] OP_MUL   = 3'b101;
  localparam logic [2:0] OP_JZ    = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  state_t              state_r, state_nxt_s;
  logic [ADDR_W-1:0]   pc_r, pc_nxt_s;
  logic [DATA_W-1:0]   acc_r, acc_nxt_s;
  logic                zero_r, zero_nxt_s;
  logic [MEM_W-1:0]    ir_r, ir_nxt_s;

  logic [2:0]          opcode_s;
  logic [ADDR_W-1:0]   opnd_s;
  logic [DATA_W-1:0]   operand_s;
  logic [2*DATA_W-1:0] prod_s;
  logic [DATA_W-1:0]   alu_s;

  logic [ADDR_W-1:0]   address_s;
  logic                rw_s;
  logic                halted_s;
  logic [MEM_W-1:0]    data_out_s;

  // Bits of the instruction word and read data outside the decoded fields
  // are intentionally ignored.
  logic unused_bits_s;
  assign unused_bits_s = ^{ir_r, data_in};

  assign opcode_s  = ir_r[MEM_W-1:MEM_W-3];
  assign opnd_s    = ir_r[ADDR_W-1:0];
  assign operand_s = data_in[DATA_W-1:0];
  // Full-width product; only the low DATA_W bits reach the accumulator.
  assign prod_s    = {{DATA_W{1'b0}}, acc_r} * {{DATA_W{1'b0}}, operand_s};

  // ALU: result of the instruction held in ir for the OPERAND cycle.
  always_comb begin
    alu_s = acc_r;
    case (opcode_s)
      OP_LOAD: alu_s = operand_s;
      OP_ADD:  alu_s = acc_r + operand_s;
      OP_SUB:  alu_s = acc_r - operand_s;
      OP_MUL:  alu_s = prod_s[DATA_W-1:0];
      default: alu_s = acc_r;
    endcase
  end

  // Next-state, register-update and memory-interface decode.
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    acc_nxt_s   = acc_r;
    zero_nxt_s  = zero_r;
    ir_nxt_s    = ir_r;
    address_s   = pc_r;
    rw_s        = 1'b1;
    halted_s    = 1'b0;
    case (state_r)
      FETCH: begin
        state_nxt_s = IR_LOAD;
      end
      IR_LOAD: begin
        ir_nxt_s    = data_in;
        // PC wraps naturally at 2^ADDR_W.
        pc_nxt_s    = pc_r + ADDR_W'(1);
        state_nxt_s = DECODE;
      end
      DECODE: begin
        case (opcode_s)
          OP_LOAD, OP_ADD, OP_SUB, OP_MUL: begin
            address_s   = opnd_s;
            state_nxt_s = OPERAND;
          end
          OP_STORE: begin
            // The only cycle in which the memory is written.
            address_s   = opnd_s;
            rw_s        = 1'b0;
            state_nxt_s = FETCH;
          end
          OP_JMP: begin
            pc_nxt_s    = opnd_s;
            state_nxt_s = FETCH;
          end
          OP_JZ: begin
            if (zero_r) begin
              pc_nxt_s = opnd_s;
            end else begin
              pc_nxt_s = pc_r;
            end
            state_nxt_s = FETCH;
          end
          OP_HALT: begin
            state_nxt_s = HALT;
          end
          default: begin
            state_nxt_s = FETCH;
          end
        endcase
      end
      OPERAND: begin
        acc_nxt_s   = alu_s;
        zero_nxt_s  = (alu_s == {DATA_W{1'b0}});
        state_nxt_s = FETCH;
      end
      HALT: begin
        halted_s    = 1'b1;
        state_nxt_s = HALT;
      end
      default: begin
        state_nxt_s = FETCH;
      end
    endcase
  end

  // Write data is the accumulator zero-extended to the memory word.
  always_comb begin
    data_out_s               = {MEM_W{1'b0}};
    data_out_s[DATA_W-1:0]   = acc_r;
  end

  // Architectural state registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= FETCH;
      pc_r    <= {ADDR_W{1'b0}};
      acc_r   <= {DATA_W{1'b0}};
      zero_r  <= 1'b0;
      ir_r    <= {MEM_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
      acc_r   <= acc_nxt_s;
      zero_r  <= zero_nxt_s;
      ir_r    <= ir_nxt_s;
    end
  end

  assign address    = address_s;
  assign readwriteN = rw_s;
  assign halted     = halted_s;
  assign data_out   = data_out_s;
  assign pc_out     = pc_r;
  assign acc_out    = acc_r;

endmodule

// File: tb/tb_processor_param.sv
// Self-checking bench for processor_param: default-parameter instance with a
// synchronous-read RAM, plus a narrow instance (DATA_W=4, ADDR_W=4, MEM_W=8).
// Expected memory writes are queued when a program is set up and popped when
// the DUT drives a write.
module tb_processor_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance
  logic        reset_n;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        readwriteN;
  logic [4:0]  address;
  logic        halted;
  logic [4:0]  pc_out;
  logic [7:0]  acc_out;

  // Narrow instance
  logic        s_reset_n;
  logic [7:0]  s_data_in;
  logic [7:0]  s_data_out;
  logic        s_readwriteN;
  logic [3:0]  s_address;
  logic        s_halted;
  logic [3:0]  s_pc_out;
  logic [3:0]  s_acc_out;

  processor_param dut (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .data_out(data_out),
    .readwriteN(readwriteN), .address(address), .halted(halted),
    .pc_out(pc_out), .acc_out(acc_out)
  );

  processor_param #(.DATA_W(4), .ADDR_W(4), .MEM_W(8)) dut_s (
    .clk(clk), .reset_n(s_reset_n), .data_in(s_data_in), .data_out(s_data_out),
    .readwriteN(s_readwriteN), .address(s_address), .halted(s_halted),
    .pc_out(s_pc_out), .acc_out(s_acc_out)
  );

  // Memories with a loader port used while the DUT is held in reset.
  logic [15:0] mem [32];
  logic        ld_we = 1'b0;
  logic [4:0]  ld_addr;
  logic [15:0] ld_data;
  logic [7:0]  mem_s [16];
  logic        ld_s_we = 1'b0;
  logic [3:0]  ld_s_addr;
  logic [7:0]  ld_s_data;

  always @(posedge clk) begin
    if (ld_we) mem[ld_addr] <= ld_data;
    else if (readwriteN === 1'b0) mem[address] <= data_out;
    data_in <= mem[address];
  end

  always @(posedge clk) begin
    if (ld_s_we) mem_s[ld_s_addr] <= ld_s_data;
    else if (s_readwriteN === 1'b0) mem_s[s_address] <= s_data_out;
    s_data_in <= mem_s[s_address];
  end

  int vectors = 0;
  int miscompares = 0;
  logic [20:0] exp_wr_q [$];   // {addr[4:0], data[15:0]}

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every write pulse must match the next queued expectation.
  always @(negedge clk) begin
    logic [20:0] e;
    if (readwriteN === 1'b0) begin
      check("write_expected", 32'(exp_wr_q.size() != 0), 32'd1);
      if (exp_wr_q.size() != 0) begin
        e = exp_wr_q.pop_front();
        check("write_addr", 32'(address), 32'(e[20:16]));
        check("write_data", 32'(data_out), 32'(e[15:0]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [4:0] a, input logic [15:0] d);
    ld_addr = a; ld_data = d; ld_we = 1'b1;
    tick();
    ld_we = 1'b0;
  endtask

  task automatic poke_s(input logic [3:0] a, input logic [7:0] d);
    ld_s_addr = a; ld_s_data = d; ld_s_we = 1'b1;
    tick();
    ld_s_we = 1'b0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 32; i++) poke(5'(i), 16'h0000);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic run_until_halt(input int max, output int cyc);
    cyc = 0;
    while (halted !== 1'b1 && cyc < max) begin
      tick();
      cyc++;
    end
    check("halt_reached", 32'(halted), 32'd1);
  endtask

  initial begin
    int cyc;
    reset_n   = 1'b0;
    s_reset_n = 1'b0;

    // ---- 1: LOAD / ADD / STORE / HALT ----
    clear_mem();
    poke(5'd0, 16'h2014); poke(5'd1, 16'h6015); poke(5'd2, 16'h4016); poke(5'd3, 16'hE000);
    poke(5'd20, 16'd7);   poke(5'd21, 16'd5);
    check("rst_address", 32'(address), 32'd0);
    check("rst_rw", 32'(readwriteN), 32'd1);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_pc", 32'(pc_out), 32'd0);
    check("rst_acc", 32'(acc_out), 32'd0);
    exp_wr_q.push_back({5'd22, 16'h000C});
    release_reset();
    run_until_halt(100, cyc);
    check("t1_halt_cycles", 32'(cyc), 32'd14);
    check("t1_acc", 32'(acc_out), 32'h0C);
    check("t1_pc", 32'(pc_out), 32'd4);
    check("t1_mem22", 32'(mem[22]), 32'h000C);
    repeat (5) tick();
    check("t1_still_halted", 32'(halted), 32'd1);
    check("t1_halt_address", 32'(address), 32'd4);
    check("t1_pending_writes", 32'(exp_wr_q.size()), 32'd0);

    // ---- 2: MUL wrap, SUB to zero, SUB negative, zero flag via JZ ----
    reset_n = 1'b0;
    #1;
    check("t2_async_rst_acc", 32'(acc_out), 32'd0);
    check("t2_async_rst_halted", 32'(halted), 32'd0);
    clear_mem();
    poke(5'd0, 16'h2014);  poke(5'd1, 16'hA015);  poke(5'd2, 16'h4018);
    poke(5'd3, 16'hC01E);  poke(5'd4, 16'h8016);  poke(5'd5, 16'h4019);
    poke(5'd6, 16'hC008);  poke(5'd7, 16'hE000);  poke(5'd8, 16'h8017);
    poke(5'd9, 16'h401A);  poke(5'd10, 16'hC01E); poke(5'd11, 16'hE000);
    poke(5'd30, 16'h401B); poke(5'd31, 16'hE000);
    poke(5'd20, 16'd20); poke(5'd21, 16'd13); poke(5'd22, 16'd4); poke(5'd23, 16'd5);
    exp_wr_q.push_back({5'd24, 16'h0004});
    exp_wr_q.push_back({5'd25, 16'h0000});
    exp_wr_q.push_back({5'd26, 16'h00FB});
    release_reset();
    run_until_halt(200, cyc);
    check("t2_acc", 32'(acc_out), 32'hFB);
    check("t2_pc", 32'(pc_out), 32'd12);
    check("t2_pending_writes", 32'(exp_wr_q.size()), 32'd0);

    // ---- 3: JZ taken after LOAD 0, not taken after LOAD 1 ----
    reset_n = 1'b0;
    clear_mem();
    poke(5'd0, 16'h2014);  poke(5'd1, 16'hC00A);  poke(5'd2, 16'hE000); poke(5'd3, 16'hE000);
    poke(5'd10, 16'h2015); poke(5'd11, 16'hC003); poke(5'd12, 16'h4016); poke(5'd13, 16'hE000);
    poke(5'd20, 16'd0); poke(5'd21, 16'd1);
    exp_wr_q.push_back({5'd22, 16'h0001});
    release_reset();
    repeat (7) tick();
    check("t3_jz_taken_pc", 32'(pc_out), 32'd10);
    check("t3_jz_taken_addr", 32'(address), 32'd10);
    run_until_halt(100, cyc);
    check("t3_pc", 32'(pc_out), 32'd14);
    check("t3_acc", 32'(acc_out), 32'd1);
    check("t3_pending_writes", 32'(exp_wr_q.size()), 32'd0);

    // ---- 4: JMP 31, PC wraps to 0 ----
    reset_n = 1'b0;
    clear_mem();
    poke(5'd0, 16'h001F); poke(5'd31, 16'h2014); poke(5'd20, 16'h0033);
    release_reset();
    repeat (5) tick();
    check("t4_pc_wrap", 32'(pc_out), 32'd0);
    repeat (2) tick();
    check("t4_fetch_addr", 32'(address), 32'd0);
    check("t4_acc", 32'(acc_out), 32'h33);
    check("t4_halted", 32'(halted), 32'd0);

    // ---- 5: reset during STORE's DECODE cycle ----
    reset_n = 1'b0;
    clear_mem();
    poke(5'd0, 16'h2014); poke(5'd1, 16'h4016); poke(5'd2, 16'hE000);
    poke(5'd20, 16'h005A); poke(5'd22, 16'h1111);
    release_reset();
    repeat (6) tick();
    check("t5_store_rw", 32'(readwriteN), 32'd0);
    check("t5_store_addr", 32'(address), 32'd22);
    reset_n = 1'b0;
    #1;
    check("t5_rst_rw", 32'(readwriteN), 32'd1);
    check("t5_rst_addr", 32'(address), 32'd0);
    check("t5_rst_acc", 32'(acc_out), 32'd0);
    check("t5_rst_halted", 32'(halted), 32'd0);
    repeat (2) tick();
    check("t5_mem22_kept", 32'(mem[22]), 32'h1111);
    exp_wr_q.push_back({5'd22, 16'h005A});
    release_reset();
    run_until_halt(100, cyc);
    check("t5_mem22_final", 32'(mem[22]), 32'h005A);
    check("t5_pending_writes", 32'(exp_wr_q.size()), 32'd0);

    // ---- 6: narrow instance, ADD wrap and PC wrap 15 -> 0 ----
    reset_n = 1'b0;
    for (int i = 0; i < 16; i++) poke_s(4'(i), 8'h00);
    poke_s(4'd0, 8'h0E); poke_s(4'd14, 8'h29); poke_s(4'd15, 8'h69); poke_s(4'd9, 8'h09);
    @(negedge clk);
    s_reset_n = 1'b1;
    repeat (7) tick();
    check("t6_load_acc", 32'(s_acc_out), 32'd9);
    repeat (2) tick();
    check("t6_pc_wrap", 32'(s_pc_out), 32'd0);
    repeat (2) tick();
    check("t6_acc_wrap", 32'(s_acc_out), 32'd2);
    check("t6_fetch_addr", 32'(s_address), 32'd0);
    check("t6_rw", 32'(s_readwriteN), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
